data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 256, number of WIDTH-bit words; power of two, 4..4096.
REQ-002 Parameter: LATENCY, 2, wait cycles before each response; 0..15.
REQ-003 Port: i_clk  input  1  single clock; all state on its rising edge.
REQ-004 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: i_req_valid  input  1  request present.
REQ-006 Port: i_memread  input  1  request is a load.
REQ-007 Port: i_memwrite  input  1  request is a store.
REQ-008 Port: i_address  input  `WIDTH  byte address.
REQ-009 Port: i_write_data  input  `WIDTH  store data.
REQ-010 Port: o_req_ready  output  1  responder can accept a request this cycle.
REQ-011 Port: o_rsp_valid  output  1  one-cycle response strobe.
REQ-012 Port: o_read_data  output  `WIDTH  load result, held between load responses.
REQ-013 Port: o_error  output  1  response is an error; qualified by o_rsp_valid.
REQ-014 Port: o_busy  output  1  stall to pipeline; high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, WAIT and RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge where state=IDLE, i_req_valid=1 and (i_memread|i_memwrite)=1, capturing address, data and opcode.
REQ-017 i_req_valid=1 with both i_memread and i_memwrite low SHALL be ignored: no acceptance, state stays IDLE.
REQ-018 Acceptance with i_memread=i_memwrite=1 SHALL produce an error response with no memory access.
REQ-019 Acceptance with i_address[1:0]!=0, or with any address bit above word-index bits [log2(DEPTH)+1:2] set, SHALL produce an error response with no memory access.
REQ-020 Transitions: IDLE->WAIT on acceptance if LATENCY>0, IDLE->RESP if LATENCY=0; WAIT->RESP after LATENCY cycles in WAIT; RESP->IDLE unconditionally.
REQ-021 o_rsp_valid SHALL be high for exactly the one cycle in RESP, starting LATENCY cycles after the cycle following acceptance; request period minimum LATENCY+2 cycles.
REQ-022 A valid store SHALL write the RAM on the edge entering RESP; a valid load SHALL read the RAM on that edge and load o_read_data.
REQ-023 An error load SHALL set o_read_data to 0; any store response SHALL leave o_read_data unchanged.
REQ-024 o_error SHALL be 0 whenever o_rsp_valid=0.
REQ-025 Input changes while not IDLE SHALL have no effect.

Reset
REQ-026 i_rst SHALL asynchronously force state IDLE, wait counter 0, o_rsp_valid 0, o_error 0, o_read_data 0, o_busy 0, o_req_ready 1.
REQ-027 Reset mid-transaction SHALL abort it; an uncommitted store SHALL NOT write the RAM.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro DMEM_POSTED_WRITE_EN: when defined, every accepted store, including errors, SHALL go IDLE->RESP regardless of LATENCY, with a valid store's write committed on the acceptance edge.
REQ-030 Without DMEM_POSTED_WRITE_EN, stores SHALL follow the same LATENCY timing as loads; loads are identical in both builds.

Verification (DEPTH=256, LATENCY=2, macro undefined unless stated)
REQ-031 Store 0xDEADBEEF to 0x10, then load 0x10 -> each o_rsp_valid 3 cycles after acceptance, o_error=0, o_read_data=0xDEADBEEF.
REQ-032 Load from 0x12, then from 0x400 -> o_error=1 on both responses, o_read_data=0x00000000.
REQ-033 Request with i_memread=i_memwrite=1 to 0x20 holding 0x1234 -> o_error=1, later load 0x20 returns 0x1234.
REQ-034 Assert i_rst during WAIT of store 0xCAFEF00D to 0x30 -> no o_rsp_valid, o_req_ready=1 immediately, later load 0x30 returns old value.
REQ-035 Back-to-back requests with i_req_valid held high -> acceptances exactly 4 cycles apart, o_busy high between.
REQ-036 DMEM_POSTED_WRITE_EN defined: store 0x55AA55AA to 0x40 -> o_rsp_valid in the cycle after acceptance; load 0x40 returns 0x55AA55AA with 3-cycle latency.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between a pipeline and data_mem_responder.
`ifndef WIDTH
`define WIDTH 32
`endif
interface data_mem_if;
    logic              i_req_valid;
    logic              i_memread;
    logic              i_memwrite;
    logic [`WIDTH-1:0] i_address;
    logic [`WIDTH-1:0] i_write_data;
    logic              o_req_ready;
    logic              o_rsp_valid;
    logic [`WIDTH-1:0] o_read_data;
    logic              o_error;
    logic              o_busy;
    modport master (
        output i_req_valid, i_memread, i_memwrite, i_address, i_write_data,
        input  o_req_ready, o_rsp_valid, o_read_data, o_error, o_busy
    );
    modport slave (
        input  i_req_valid, i_memread, i_memwrite, i_address, i_write_data,
        output o_req_ready, o_rsp_valid, o_read_data, o_error, o_busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM answering one load/store at a time after LATENCY wait cycles.
// Define DMEM_POSTED_WRITE_EN to answer every store in the cycle after acceptance.
`ifndef WIDTH
`define WIDTH 32
`endif
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic        i_clk,
    input logic        i_rst,
    data_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic [`WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [`WIDTH-1:0] mem [DEPTH];
    logic              idle, accept, bad_now, fast, go_resp, we;
    logic              op_rd, op_wr, op_err;
    logic [`WIDTH-1:0] op_addr, op_wdata;
    logic [AW-1:0]     idx;
    assign idle    = state_q == IDLE;
    assign accept  = idle & bus.i_req_valid & (bus.i_memread | bus.i_memwrite);
    assign bad_now = (bus.i_memread & bus.i_memwrite) | (|bus.i_address[1:0])
                   | (|(bus.i_address >> (AW + 2)));
`ifdef DMEM_POSTED_WRITE_EN
    assign fast = (LATENCY == 0) | bus.i_memwrite;
`else
    assign fast = LATENCY == 0;
`endif
    // The access happens on the edge entering RESP; from IDLE that edge is the acceptance edge.
    assign op_rd    = idle ? bus.i_memread    : rd_q;
    assign op_wr    = idle ? bus.i_memwrite   : wr_q;
    assign op_err   = idle ? bad_now          : err_q;
    assign op_addr  = idle ? bus.i_address    : addr_q;
    assign op_wdata = idle ? bus.i_write_data : wdata_q;
    assign idx      = op_addr[AW+1:2];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                rd_d    = bus.i_memread;
                wr_d    = bus.i_memwrite;
                err_d   = bad_now;
                addr_d  = bus.i_address;
                wdata_d = bus.i_write_data;
                cnt_d   = 4'd0;
                go_resp = fast;
                state_d = fast ? RESP : WAIT;
            end
            WAIT: begin
                go_resp = cnt_q == LAT - 4'd1;
                cnt_d   = go_resp ? 4'd0 : cnt_q + 4'd1;
                state_d = go_resp ? RESP : WAIT;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        we      = go_resp & op_wr & ~op_err;
        rdata_d = (go_resp & op_rd & ~op_wr) ? (op_err ? '0 : mem[idx]) : rdata_q;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (we) mem[idx] <= op_wdata;
    end
    assign bus.o_req_ready = idle;
    assign bus.o_busy      = ~idle;
    assign bus.o_rsp_valid = state_q == RESP;
    assign bus.o_error     = (state_q == RESP) & err_q;
    assign bus.o_read_data = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (DEPTH=256, LATENCY=2).
`ifndef WIDTH
`define WIDTH 32
`endif
module tb_data_mem_responder;
    localparam int LAT = 2;
`ifdef DMEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    typedef struct {
        int          t;
        logic        err;
        logic [31:0] data;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] ref_mem [256];
    logic [31:0] model_rd = 32'h0;
    bit          b2b = 1'b0;
    int          prev_acc = -1;
    data_mem_if bus();
    data_mem_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        check("busy_vs_ready", 32'(bus.o_busy), 32'(!bus.o_req_ready));
        if (bus.o_rsp_valid) begin
            if (sb.size() == 0) check("unexpected_rsp", 32'(1), 32'(0));
            else begin
                e = sb.pop_front();
                check("rsp_time", 32'(cyc), 32'(e.t));
                check("rsp_error", 32'(bus.o_error), 32'(e.err));
                check("rsp_data", bus.o_read_data, e.data);
            end
        end else check("error_idle", 32'(bus.o_error), 32'(0));
    end
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.i_req_valid  = 1'b1;
        bus.i_memread    = rd;
        bus.i_memwrite   = wr;
        bus.i_address    = a;
        bus.i_write_data = d;
    endtask
    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!bus.o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.o_req_ready;
        if (!ok) check("accept_timeout", 32'(0), 32'(1));
    endtask
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   ok;
        logic err;
        @(negedge clk);
        drive(rd, wr, a, d);
        wait_ready(ok);
        if (!ok) return;
        err = (rd & wr) | (a[1:0] != 2'b00) | ((a >> 10) != 0);
        if (rd & !wr) model_rd = err ? 32'h0 : ref_mem[a[9:2]];
        if (wr & !err) ref_mem[a[9:2]] = d;
        e.t    = cyc + ((POSTED && wr) ? 1 : LAT + 1);
        e.err  = err;
        e.data = model_rd;
        sb.push_back(e);
        if (b2b && prev_acc >= 0) check("b2b_gap", 32'(cyc - prev_acc), 32'(LAT + 2));
        prev_acc = cyc;
        @(posedge clk);
    endtask
    task automatic go_idle(input int n);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask
    task automatic reset_mid(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        @(negedge clk);
        drive(rd, wr, a, d);
        wait_ready(ok);
        if (!ok) return;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(bus.o_busy), 32'(1));
        bus.i_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus.o_req_ready), 32'(1));
        check("rst_busy", 32'(bus.o_busy), 32'(0));
        check("rst_rsp", 32'(bus.o_rsp_valid), 32'(0));
        check("rst_rdata", bus.o_read_data, 32'h0);
        model_rd = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        bit ok;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        bus.i_req_valid = 1'b0;
        #1;
        check("reset_ready", 32'(bus.o_req_ready), 32'(1));
        check("reset_busy", 32'(bus.o_busy), 32'(0));
        check("reset_rsp", 32'(bus.o_rsp_valid), 32'(0));
        check("reset_error", 32'(bus.o_error), 32'(0));
        check("reset_rdata", bus.o_read_data, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);
        go_idle(2);
        do_req(1'b1, 1'b0, 32'h12, 32'h0);
        do_req(1'b1, 1'b0, 32'h400, 32'h0);
        go_idle(2);
        do_req(1'b0, 1'b1, 32'h20, 32'h1234);
        do_req(1'b1, 1'b1, 32'h20, 32'hFFFF0000);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);
        go_idle(6);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h24, 32'h77);
        repeat (3) begin
            @(negedge clk);
            check("ignored_ready", 32'(bus.o_req_ready), 32'(1));
        end
        go_idle(1);
        do_req(1'b0, 1'b1, 32'h30, 32'h11111111);
        go_idle(4);
        if (POSTED) reset_mid(1'b1, 1'b0, 32'h30, 32'h0);
        else reset_mid(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
        go_idle(2);
        do_req(1'b1, 1'b0, 32'h30, 32'h0);
        go_idle(4);
        do_req(1'b0, 1'b1, 32'h40, 32'h55AA55AA);
        go_idle(1);
        do_req(1'b1, 1'b0, 32'h40, 32'h0);
        go_idle(4);
        b2b = 1'b1;
        prev_acc = -1;
        do_req(1'b1, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);
        do_req(1'b1, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 1'b0, 32'h30, 32'h0);
        do_req(1'b1, 1'b0, 32'h3FC, 32'h0);
        b2b = 1'b0;
        go_idle(4);
        for (int k = 0; k < 8; k++) do_req(1'b0, 1'b1, 32'h50 + 32'(4 * k), $urandom);
        for (int i = 0; i < 16; i++) begin
            int k = $urandom_range(0, 7);
            int kind = $urandom_range(0, 3);
            logic [31:0] a = 32'h50 + 32'(4 * k);
            if (kind == 0) do_req(1'b0, 1'b1, a, $urandom);
            else if (kind == 3) do_req(1'b1, 1'b0, a + 32'h1, 32'h0);
            else do_req(1'b1, 1'b0, a, 32'h0);
            if ($urandom_range(0, 1) == 1) go_idle($urandom_range(0, 3));
        end
        go_idle(1);
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
